// File: rtl/frame_blit_engine.sv
// Rectangular frame-buffer blitter: reads a region of one of NUM_BUFFERS frame
// buffers through a latency-matched tag pipeline and drives the VGA plot port.
module frame_blit_engine #(
  parameter  int SCREEN_WIDTH  = 320,
  parameter  int SCREEN_HEIGHT = 240,
  parameter  int COLOUR_BITS   = 9,
  parameter  int NUM_BUFFERS   = 2,
  parameter  int READ_LATENCY  = 1,
  parameter  int ADDR_BITS     = 17,
  localparam int CW = $clog2(((SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT) + 1),
  localparam int BW = $clog2(NUM_BUFFERS)
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iStart,
  input  logic [BW-1:0]          iBufSel,
  input  logic [CW-1:0]          iX0,
  input  logic [CW-1:0]          iY0,
  input  logic [CW-1:0]          iX1,
  input  logic [CW-1:0]          iY1,
  input  logic                   iAbort,
  input  logic [COLOUR_BITS-1:0] iQ,
  output logic                   oRdEn,
  output logic [ADDR_BITS-1:0]   oAddress,
  output logic [BW-1:0]          oBufSel,
  output logic [COLOUR_BITS-1:0] oColour,
  output logic [CW-1:0]          ox,
  output logic [CW-1:0]          oy,
  output logic                   oPlot,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [1:0]             oStatus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [1:0]           ST_OK    = 2'b00;
  localparam logic [1:0]           ST_BAD   = 2'b01;
  localparam logic [1:0]           ST_ABORT = 2'b10;
  localparam logic [CW-1:0]        W_C      = CW'(SCREEN_WIDTH);
  localparam logic [CW-1:0]        H_C      = CW'(SCREEN_HEIGHT);
  localparam logic [ADDR_BITS-1:0] W_A      = ADDR_BITS'(SCREEN_WIDTH);

  state_t                  state;
  logic [CW-1:0]           x0_q, x1_q, y1_q;
  logic [CW-1:0]           x, y;
  logic [ADDR_BITS-1:0]    rowbase;
  logic [READ_LATENCY-1:0] vld_p;
  logic [CW-1:0]           tag_x_p [READ_LATENCY];
  logic [CW-1:0]           tag_y_p [READ_LATENCY];

  logic copying, abort_now, push, last_pix, bad_rect;

  assign copying   = (state == ISSUE) || (state == DRAIN);
  assign abort_now = iAbort && copying;
  assign push      = (state == ISSUE) && !abort_now;
  assign last_pix  = (x == x1_q) && (y == y1_q);
  assign bad_rect  = (iX0 > iX1) || (iY0 > iY1) || (iX1 >= W_C) || (iY1 >= H_C);

  // Tag pipeline p0..p(L-1): coordinates of each issued read, aligned with iQ
  always_ff @(posedge iClk) begin
    tag_x_p[0] <= x;
    tag_y_p[0] <= y;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_x_p[i] <= tag_x_p[i-1];
      tag_y_p[i] <= tag_y_p[i-1];
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state    <= IDLE;
      vld_p    <= '0;
      oRdEn    <= 1'b0;
      oAddress <= '0;
      oBufSel  <= '0;
      oColour  <= '1;
      ox       <= '0;
      oy       <= '0;
      oPlot    <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oStatus  <= ST_OK;
    end else begin
      vld_p[0] <= push;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      if (abort_now) vld_p <= '0;

      // Output stage: entry leaving the last pipeline slot becomes a plot
      oDone <= 1'b0;
      oPlot <= 1'b0;
      if (vld_p[READ_LATENCY-1] && !abort_now) begin
        oPlot   <= 1'b1;
        oColour <= iQ;
        ox      <= tag_x_p[READ_LATENCY-1];
        oy      <= tag_y_p[READ_LATENCY-1];
      end

      case (state)
        IDLE: begin
          if (iStart) begin
            oBufSel <= iBufSel;
            x0_q    <= iX0;
            x1_q    <= iX1;
            y1_q    <= iY1;
            if (bad_rect) begin
              state   <= DONE;
              oDone   <= 1'b1;
              oStatus <= ST_BAD;
            end else begin
              x        <= iX0;
              y        <= iY0;
              rowbase  <= ADDR_BITS'(iY0) * W_A;
              oAddress <= ADDR_BITS'(iY0) * W_A + ADDR_BITS'(iX0);
              oRdEn    <= 1'b1;
              oBusy    <= 1'b1;
              oStatus  <= ST_OK;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (abort_now) begin
            oRdEn   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            oStatus <= ST_ABORT;
            state   <= DONE;
          end else if (last_pix) begin
            oRdEn <= 1'b0;
            state <= DRAIN;
          end else if (x == x1_q) begin
            x        <= x0_q;
            y        <= y + CW'(1);
            rowbase  <= rowbase + W_A;
            oAddress <= rowbase + W_A + ADDR_BITS'(x0_q);
          end else begin
            x        <= x + CW'(1);
            oAddress <= oAddress + ADDR_BITS'(1);
          end
        end
        DRAIN: begin
          if (abort_now) begin
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            oStatus <= ST_ABORT;
            state   <= DONE;
          end else if (vld_p == '0) begin
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            oStatus <= ST_OK;
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_blit_engine.sv
// Bench for frame_blit_engine: three instances (L=1, L=3, L=2/4 buffers) checked
// every cycle against a closed-form timing model plus literal expectations.
module tb_frame_blit_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: L=1, 2 buffers
  logic a_rst, a_start, a_abort;
  logic [0:0] a_bsel_i, a_bsel;
  logic [8:0] a_x0, a_y0, a_x1, a_y1, a_q, a_col, a_ox, a_oy;
  logic a_rden, a_plot, a_busy, a_done;
  logic [16:0] a_addr;
  logic [1:0] a_status;
  // Instance B: L=3, 2 buffers
  logic b_rst, b_start, b_abort;
  logic [0:0] b_bsel_i, b_bsel;
  logic [8:0] b_x0, b_y0, b_x1, b_y1, b_q, b_col, b_ox, b_oy;
  logic b_rden, b_plot, b_busy, b_done;
  logic [16:0] b_addr;
  logic [1:0] b_status;
  // Instance C: L=2, 4 buffers
  logic c_rst, c_start, c_abort;
  logic [1:0] c_bsel_i, c_bsel;
  logic [8:0] c_x0, c_y0, c_x1, c_y1, c_q, c_col, c_ox, c_oy;
  logic c_rden, c_plot, c_busy, c_done;
  logic [16:0] c_addr;
  logic [1:0] c_status;

  frame_blit_engine #(.READ_LATENCY(1), .NUM_BUFFERS(2)) dut_a (
    .iClk(clk), .iReset(a_rst), .iStart(a_start), .iBufSel(a_bsel_i),
    .iX0(a_x0), .iY0(a_y0), .iX1(a_x1), .iY1(a_y1), .iAbort(a_abort), .iQ(a_q),
    .oRdEn(a_rden), .oAddress(a_addr), .oBufSel(a_bsel), .oColour(a_col),
    .ox(a_ox), .oy(a_oy), .oPlot(a_plot), .oBusy(a_busy), .oDone(a_done), .oStatus(a_status));

  frame_blit_engine #(.READ_LATENCY(3), .NUM_BUFFERS(2)) dut_b (
    .iClk(clk), .iReset(b_rst), .iStart(b_start), .iBufSel(b_bsel_i),
    .iX0(b_x0), .iY0(b_y0), .iX1(b_x1), .iY1(b_y1), .iAbort(b_abort), .iQ(b_q),
    .oRdEn(b_rden), .oAddress(b_addr), .oBufSel(b_bsel), .oColour(b_col),
    .ox(b_ox), .oy(b_oy), .oPlot(b_plot), .oBusy(b_busy), .oDone(b_done), .oStatus(b_status));

  frame_blit_engine #(.READ_LATENCY(2), .NUM_BUFFERS(4)) dut_c (
    .iClk(clk), .iReset(c_rst), .iStart(c_start), .iBufSel(c_bsel_i),
    .iX0(c_x0), .iY0(c_y0), .iX1(c_x1), .iY1(c_y1), .iAbort(c_abort), .iQ(c_q),
    .oRdEn(c_rden), .oAddress(c_addr), .oBufSel(c_bsel), .oColour(c_col),
    .ox(c_ox), .oy(c_oy), .oPlot(c_plot), .oBusy(c_busy), .oDone(c_done), .oStatus(c_status));

  // RAM contents per instance, as a function of pixel address
  function automatic int ram_fn(input int d, input int addr);
    case (d)
      0:       return addr & 511;
      1:       return (addr ^ 346) & 511;
      default: return (addr * 3 + 1) & 511;
    endcase
  endfunction

  logic [16:0] ra_a [1];
  logic [16:0] ra_b [3];
  logic [16:0] ra_c [2];
  always @(posedge clk) begin
    ra_a[0] <= a_addr;
    ra_b[0] <= b_addr; ra_b[1] <= ra_b[0]; ra_b[2] <= ra_b[1];
    ra_c[0] <= c_addr; ra_c[1] <= ra_c[0];
  end
  assign a_q = 9'(ram_fn(0, int'(ra_a[0])));
  assign b_q = 9'(ram_fn(1, int'(ra_b[2])));
  assign c_q = 9'(ram_fn(2, int'(ra_c[1])));

  // Model state: mode 0 = expect reset values, 1 = job started at jt
  int mode [3];
  int jt [3], jx0 [3], jy0 [3], jx1 [3], jy1 [3], jbuf [3], jab [3];
  bit jbad [3];
  int lat [3] = '{1, 3, 2};

  int rd_cnt [3], pl_cnt [3], dn_cnt [3], dn_cyc [3], last_addr [3], last_px [3], last_py [3];
  int addr_q [$];
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input int d, input int rden, input int addr, input int bsel,
                           input int col, input int px, input int py, input int plot,
                           input int busy, input int done, input int status);
    int c, t, n, w, iss_end, dn_c, k, ex, ey;
    bit e_rd, e_pl;
    c = cyc;
    if (rden != 0) begin
      rd_cnt[d]++;
      last_addr[d] = addr;
      if (d == 1) addr_q.push_back(addr);
    end
    if (plot != 0) begin
      pl_cnt[d]++;
      last_px[d] = px;
      last_py[d] = py;
    end
    if (done != 0) begin
      dn_cnt[d]++;
      dn_cyc[d] = c;
    end
    if (mode[d] == 0) begin
      chk("rst_rden", d, rden, 0);     chk("rst_addr", d, addr, 0);
      chk("rst_bufsel", d, bsel, 0);   chk("rst_colour", d, col, 511);
      chk("rst_x", d, px, 0);          chk("rst_y", d, py, 0);
      chk("rst_plot", d, plot, 0);     chk("rst_busy", d, busy, 0);
      chk("rst_done", d, done, 0);     chk("rst_status", d, status, 0);
      return;
    end
    if (c <= jt[d]) begin
      chk("pre_rden", d, rden, 0); chk("pre_plot", d, plot, 0);
      chk("pre_done", d, done, 0); chk("pre_busy", d, busy, 0);
      return;
    end
    chk("bufsel", d, bsel, jbuf[d]);
    if (jbad[d]) begin
      chk("bad_rden", d, rden, 0); chk("bad_plot", d, plot, 0);
      chk("bad_busy", d, busy, 0); chk("bad_done", d, done, int'(c == jt[d] + 1));
      chk("bad_status", d, status, 1);
      return;
    end
    w = jx1[d] - jx0[d] + 1;
    n = w * (jy1[d] - jy0[d] + 1);
    iss_end = jt[d] + n;
    if (jab[d] >= 0 && jab[d] < iss_end) iss_end = jab[d];
    dn_c = (jab[d] >= 0) ? jab[d] + 1 : jt[d] + n + lat[d] + 2;
    e_rd = (c >= jt[d] + 1) && (c <= iss_end);
    chk("rden", d, rden, int'(e_rd));
    if (e_rd) begin
      k = c - jt[d] - 1;
      chk("addr", d, addr, (jy0[d] + k / w) * 320 + jx0[d] + k % w);
    end
    t = c - lat[d] - 1;
    e_pl = (t >= jt[d] + 1) && (t <= iss_end) && (jab[d] < 0 || c <= jab[d]);
    chk("plot", d, plot, int'(e_pl));
    if (e_pl) begin
      k = t - jt[d] - 1;
      ex = jx0[d] + k % w;
      ey = jy0[d] + k / w;
      chk("plot_x", d, px, ex);
      chk("plot_y", d, py, ey);
      chk("colour", d, col, ram_fn(d, ey * 320 + ex));
    end
    chk("busy", d, busy, int'(c >= jt[d] + 1 && c < dn_c));
    chk("done", d, done, int'(c == dn_c));
    if (c >= dn_c) chk("status", d, status, (jab[d] >= 0) ? 2 : 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, int'(a_rden), int'(a_addr), int'(a_bsel), int'(a_col), int'(a_ox), int'(a_oy),
                int'(a_plot), int'(a_busy), int'(a_done), int'(a_status));
      check_dut(1, int'(b_rden), int'(b_addr), int'(b_bsel), int'(b_col), int'(b_ox), int'(b_oy),
                int'(b_plot), int'(b_busy), int'(b_done), int'(b_status));
      check_dut(2, int'(c_rden), int'(c_addr), int'(c_bsel), int'(c_col), int'(c_ox), int'(c_oy),
                int'(c_plot), int'(c_busy), int'(c_done), int'(c_status));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit st, input int bsel,
                       input int x0, input int y0, input int x1, input int y1);
    case (d)
      0: begin a_start = st; a_bsel_i = 1'(bsel); a_x0 = 9'(x0); a_y0 = 9'(y0); a_x1 = 9'(x1); a_y1 = 9'(y1); end
      1: begin b_start = st; b_bsel_i = 1'(bsel); b_x0 = 9'(x0); b_y0 = 9'(y0); b_x1 = 9'(x1); b_y1 = 9'(y1); end
      default: begin c_start = st; c_bsel_i = 2'(bsel); c_x0 = 9'(x0); c_y0 = 9'(y0); c_x1 = 9'(x1); c_y1 = 9'(y1); end
    endcase
  endtask

  task automatic clear_start(input int d);
    case (d)
      0: a_start = 1'b0;
      1: b_start = 1'b0;
      default: c_start = 1'b0;
    endcase
  endtask

  task automatic start_job(input int d, input int bsel, input int x0, input int y0,
                           input int x1, input int y1);
    drive(d, 1'b1, bsel, x0, y0, x1, y1);
    mode[d] = 1; jt[d] = cyc; jbuf[d] = bsel; jab[d] = -1;
    jx0[d] = x0; jy0[d] = y0; jx1[d] = x1; jy1[d] = y1;
    jbad[d] = (x0 > x1) || (y0 > y1) || (x1 >= 320) || (y1 >= 240);
    rd_cnt[d] = 0; pl_cnt[d] = 0; dn_cnt[d] = 0; dn_cyc[d] = -1;
    if (d == 1) addr_q.delete();
    tick();
    clear_start(d);
  endtask

  task automatic wait_done(input int d, input int budget);
    int i;
    i = 0;
    while (dn_cnt[d] == 0 && i < budget) begin
      tick();
      i++;
    end
    chk("done_within_budget", d, int'(dn_cnt[d] > 0), 1);
    tick();
    tick();
  endtask

  int t0, ab;
  int exp_sub [6] = '{1610, 1611, 1612, 1930, 1931, 1932};

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_abort = 1'b0; b_abort = 1'b0; c_abort = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mode[d] = 0; jab[d] = -1;
      drive(d, 1'b0, 0, 0, 0, 0, 0);
    end
    tick();
    chk_en = 1'b1;
    tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();
    chk("reset_colour_lit", 0, int'(a_col), 511);
    chk("reset_addr_lit", 2, int'(c_addr), 0);

    // Bad rectangle: X0 > X1
    start_job(0, 1, 20, 0, 19, 0);
    t0 = jt[0];
    wait_done(0, 10);
    chk("bad1_done_cycle", 0, dn_cyc[0], t0 + 1);
    chk("bad1_reads", 0, rd_cnt[0], 0);
    chk("bad1_plots", 0, pl_cnt[0], 0);
    chk("bad1_status", 0, int'(a_status), 1);

    // Bad rectangle: X1 off-screen
    start_job(0, 1, 0, 0, 320, 0);
    t0 = jt[0];
    wait_done(0, 10);
    chk("bad2_done_cycle", 0, dn_cyc[0], t0 + 1);
    chk("bad2_reads", 0, rd_cnt[0], 0);
    chk("bad2_plots", 0, pl_cnt[0], 0);
    chk("bad2_status", 0, int'(a_status), 1);

    // Sub-rectangle (10,5)-(12,6) at L=3
    start_job(1, 0, 10, 5, 12, 6);
    t0 = jt[1];
    wait_done(1, 40);
    chk("sub_read_count", 1, addr_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < addr_q.size()) chk("sub_addr", 1, addr_q[i], exp_sub[i]);
    chk("sub_plots", 1, pl_cnt[1], 6);
    chk("sub_done_cycle", 1, dn_cyc[1], t0 + 11);
    chk("sub_done_count", 1, dn_cnt[1], 1);

    // Abort 50 cycles into a full-screen copy at L=2
    start_job(2, 2, 0, 0, 319, 239);
    t0 = jt[2];
    repeat (49) tick();
    c_abort = 1'b1;
    ab = cyc;
    jab[2] = ab;
    tick();
    c_abort = 1'b0;
    wait_done(2, 10);
    chk("abort_at", 2, ab, t0 + 50);
    chk("abort_plots", 2, pl_cnt[2], 47);
    chk("abort_done_cycle", 2, dn_cyc[2], ab + 1);
    chk("abort_status", 2, int'(c_status), 2);

    // Following start, 1x1 corner on buffer 3
    start_job(2, 3, 319, 239, 319, 239);
    t0 = jt[2];
    wait_done(2, 20);
    chk("corner_reads", 2, rd_cnt[2], 1);
    chk("corner_addr", 2, last_addr[2], 76799);
    chk("corner_plots", 2, pl_cnt[2], 1);
    chk("corner_x", 2, last_px[2], 319);
    chk("corner_y", 2, last_py[2], 239);
    chk("corner_bufsel", 2, int'(c_bsel), 3);
    chk("corner_done_cycle", 2, dn_cyc[2], t0 + 5);

    // Full screen on buffer 1 with an ignored start mid-copy
    start_job(0, 1, 0, 0, 319, 239);
    t0 = jt[0];
    repeat (99) tick();
    drive(0, 1'b1, 0, 0, 0, 1, 1);
    tick();
    clear_start(0);
    tick();
    chk("busy_start_bufsel", 0, int'(a_bsel), 1);
    wait_done(0, 77000);
    chk("full_plots", 0, pl_cnt[0], 76800);
    chk("full_reads", 0, rd_cnt[0], 76800);
    chk("full_done_cycle", 0, dn_cyc[0], t0 + 76803);
    chk("full_status", 0, int'(a_status), 0);
    chk("full_bufsel", 0, int'(a_bsel), 1);

    // Reset in the middle of a copy
    start_job(0, 1, 0, 0, 319, 239);
    repeat (20) tick();
    a_rst = 1'b1;
    tick();
    mode[0] = 0;
    a_rst = 1'b0;
    repeat (5) tick();
    chk("midreset_no_done", 0, dn_cnt[0], 0);
    chk("midreset_plot", 0, int'(a_plot), 0);
    chk("midreset_colour", 0, int'(a_col), 511);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
